huff_region_sched: RTL and testbench

HUFF_REGION_SCHED -- requirements
Module: huff_region_sched

---
 rtl/mp3_pkg.sv | 28 ++
 rtl/huff_region_sched_if.sv | 48 ++++
 rtl/huff_region_select.sv | 24 ++
 rtl/huff_region_sched.sv | 196 +++++++++++++++++++
 tb/tb_huff_region_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp3_pkg.sv
// Shared constants, state encoding and helpers for the Huffman region scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp3_pkg;

  localparam int MAX_PAIRS = 288;
  localparam int TID_W     = 5;
  localparam int SMP_W     = 16;
  localparam int IDX_W     = 9;
  localparam int BITS_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EMIT_Y,
    ST_ZERO_X,
    ST_ZERO_Y,
    ST_DONE
  } state_t;

  // Limit a requested pair count to what the granule buffer can hold.
  function automatic logic [IDX_W-1:0] clamp_pairs(input logic [IDX_W-1:0] bv,
                                                   input int unsigned max_p);
    if (32'(bv) > max_p) return max_p[IDX_W-1:0];
    return bv;
  endfunction

endpackage

// File: rtl/huff_region_sched_if.sv
// Bundle of control, bitstream, decoder-bank and sample-output signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the bitstream; decoder results are never stalled.
interface huff_region_sched_if;
  import mp3_pkg::*;

  logic                    start;
  logic [IDX_W-1:0]        big_values;
  logic [IDX_W-1:0]        r1_start;
  logic [IDX_W-1:0]        r2_start;
  logic [TID_W-1:0]        tsel0;
  logic [TID_W-1:0]        tsel1;
  logic [TID_W-1:0]        tsel2;

  logic                    in_axiiv;
  logic                    in_axiid;
  logic                    in_ready;

  logic [TID_W-1:0]        dec_sel;
  logic                    dec_axiiv;
  logic                    dec_axiid;
  logic                    dec_axiov;
  logic signed [SMP_W-1:0] dec_x;
  logic signed [SMP_W-1:0] dec_y;

  logic                    out_valid;
  logic [IDX_W:0]          out_idx;
  logic signed [SMP_W-1:0] out_val;

  logic                    busy;
  logic                    done;
  logic [BITS_W-1:0]       bits_used;

  modport slave (
    input  start, big_values, r1_start, r2_start, tsel0, tsel1, tsel2,
    input  in_axiiv, in_axiid, dec_axiov, dec_x, dec_y,
    output in_ready, dec_sel, dec_axiiv, dec_axiid,
    output out_valid, out_idx, out_val, busy, done, bits_used
  );

  modport master (
    output start, big_values, r1_start, r2_start, tsel0, tsel1, tsel2,
    output in_axiiv, in_axiid, dec_axiov, dec_x, dec_y,
    input  in_ready, dec_sel, dec_axiiv, dec_axiid,
    input  out_valid, out_idx, out_val, busy, done, bits_used
  );

endinterface

// File: rtl/huff_region_select.sv
// Maps a pair index onto its big_values region and returns that region's table id.
// Latency: purely combinational.
// Backpressure: none.
module huff_region_select
  import mp3_pkg::*;
(
  input  logic [IDX_W-1:0] i_pair_idx,
  input  logic [IDX_W-1:0] i_r1_start,
  input  logic [IDX_W-1:0] i_r2_start,
  input  logic [TID_W-1:0] i_tsel0,
  input  logic [TID_W-1:0] i_tsel1,
  input  logic [TID_W-1:0] i_tsel2,
  output logic [TID_W-1:0] o_sel
);

  // Region 0 below r1_start, region 1 below r2_start, region 2 otherwise;
  // an r2_start below r1_start simply leaves region 1 empty.
  always_comb begin
    if (i_pair_idx < i_r1_start)      o_sel = i_tsel0;
    else if (i_pair_idx < i_r2_start) o_sel = i_tsel1;
    else                              o_sel = i_tsel2;
  end

endmodule

// File: rtl/huff_region_sched.sv
// Steers one granule/channel of big_values pairs through the Huffman decoder bank.
// Latency: x sample same cycle as dec_axiov, y sample next cycle; table-0 pairs take 2 cycles.
// Backpressure: in_ready drops on decoder result, EMIT_Y and zero-fill cycles.
module huff_region_sched #(
  parameter int MAX_PAIRS = mp3_pkg::MAX_PAIRS
) (
  input logic                clk,
  input logic                rst,
  huff_region_sched_if.slave bus
);
  import mp3_pkg::*;

  state_t                  r_state;
  state_t                  w_next;

  logic [IDX_W-1:0]        r_big;
  logic [IDX_W-1:0]        r_r1;
  logic [IDX_W-1:0]        r_r2;
  logic [TID_W-1:0]        r_t0;
  logic [TID_W-1:0]        r_t1;
  logic [TID_W-1:0]        r_t2;
  logic [IDX_W-1:0]        r_pair;
  logic signed [SMP_W-1:0] r_y;
  logic [BITS_W-1:0]       r_bits;

  logic                    w_idle;
  logic                    w_start;
  logic [IDX_W-1:0]        w_big_clamp;
  logic [IDX_W-1:0]        w_pair_inc;
  logic                    w_last;
  logic [IDX_W-1:0]        w_la_idx;
  logic [IDX_W-1:0]        w_la_r1;
  logic [IDX_W-1:0]        w_la_r2;
  logic [TID_W-1:0]        w_la_t0;
  logic [TID_W-1:0]        w_la_t1;
  logic [TID_W-1:0]        w_la_t2;
  logic [TID_W-1:0]        w_cur_sel;
  logic [TID_W-1:0]        w_nxt_sel;
  logic                    w_take;

  logic                    w_in_ready;
  logic                    w_out_valid;
  logic [IDX_W:0]          w_out_idx;
  logic signed [SMP_W-1:0] w_out_val;
  logic                    w_busy;
  logic                    w_done;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start     = w_idle && bus.start;
  assign w_big_clamp = clamp_pairs(bus.big_values, MAX_PAIRS);
  assign w_pair_inc  = r_pair + IDX_W'(1);
  assign w_last      = (w_pair_inc == r_big);

  // The lookahead selector answers "which table does the next pair use?".
  // In IDLE the registers are stale, so it looks at pair 0 of the incoming
  // configuration; afterwards it looks one pair ahead of the current one.
  assign w_la_idx = w_idle ? '0            : w_pair_inc;
  assign w_la_r1  = w_idle ? bus.r1_start  : r_r1;
  assign w_la_r2  = w_idle ? bus.r2_start  : r_r2;
  assign w_la_t0  = w_idle ? bus.tsel0     : r_t0;
  assign w_la_t1  = w_idle ? bus.tsel1     : r_t1;
  assign w_la_t2  = w_idle ? bus.tsel2     : r_t2;

  // The pair index only moves between pairs, so dec_sel never changes inside a codeword.
  huff_region_select u_cur_sel (
    .i_pair_idx (r_pair),
    .i_r1_start (r_r1),
    .i_r2_start (r_r2),
    .i_tsel0    (r_t0),
    .i_tsel1    (r_t1),
    .i_tsel2    (r_t2),
    .o_sel      (w_cur_sel)
  );

  huff_region_select u_nxt_sel (
    .i_pair_idx (w_la_idx),
    .i_r1_start (w_la_r1),
    .i_r2_start (w_la_r2),
    .i_tsel0    (w_la_t0),
    .i_tsel1    (w_la_t1),
    .i_tsel2    (w_la_t2),
    .o_sel      (w_nxt_sel)
  );

  assign w_take        = bus.in_axiiv && w_in_ready;

  assign bus.dec_sel   = w_cur_sel;
  assign bus.dec_axiiv = w_take;
  assign bus.dec_axiid = bus.in_axiid;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_idx   = w_out_idx;
  assign bus.out_val   = w_out_val;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.bits_used = r_bits;

  // State register; reset abandons any granule in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: start only counts in IDLE, and every pair boundary picks the
  // following pair's path (zero-fill for table 0, decode otherwise).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_big_clamp == '0)     w_next = ST_DONE;
          else if (w_nxt_sel == '0)  w_next = ST_ZERO_X;
          else                       w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.dec_axiov) w_next = ST_EMIT_Y;
      end
      ST_EMIT_Y, ST_ZERO_Y: begin
        if (w_last)               w_next = ST_DONE;
        else if (w_nxt_sel == '0) w_next = ST_ZERO_X;
        else                      w_next = ST_DECODE;
      end
      ST_ZERO_X: w_next = ST_ZERO_Y;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs: x is forwarded straight from the decoder, y replays from its latch,
  // zero-fill pairs emit literal zeros; the bitstream is held whenever a sample goes out.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_idx   = '0;
    w_out_val   = '0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_DECODE: begin
        w_in_ready = !bus.dec_axiov;
        if (bus.dec_axiov) begin
          w_out_valid = 1'b1;
          w_out_idx   = {r_pair, 1'b0};
          w_out_val   = bus.dec_x;
        end
      end
      ST_EMIT_Y: begin
        w_out_valid = 1'b1;
        w_out_idx   = {r_pair, 1'b1};
        w_out_val   = r_y;
      end
      ST_ZERO_X: begin
        w_out_valid = 1'b1;
        w_out_idx   = {r_pair, 1'b0};
      end
      ST_ZERO_Y: begin
        w_out_valid = 1'b1;
        w_out_idx   = {r_pair, 1'b1};
      end
      ST_DONE: w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Granule datapath: configuration latched at start, saturating bit counter,
  // y latch and pair counter that advances once per completed pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_big  <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      r_t0   <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_pair <= '0;
      r_y    <= '0;
      r_bits <= '0;
    end else if (w_start) begin
      r_big  <= w_big_clamp;
      r_r1   <= bus.r1_start;
      r_r2   <= bus.r2_start;
      r_t0   <= bus.tsel0;
      r_t1   <= bus.tsel1;
      r_t2   <= bus.tsel2;
      r_pair <= '0;
      r_bits <= '0;
    end else begin
      if (w_take && (r_bits != '1)) r_bits <= r_bits + BITS_W'(1);
      if ((r_state == ST_DECODE) && bus.dec_axiov) r_y <= bus.dec_y;
      if ((r_state == ST_EMIT_Y) || (r_state == ST_ZERO_Y)) r_pair <= w_pair_inc;
    end
  end

endmodule

// File: tb/tb_huff_region_sched.sv
// Directed bench for huff_region_sched with a toy 4-bit-codeword decoder bank.
// Latency: n/a.
// Backpressure: bitstream source honours in_ready, optionally with random gaps.
module tb_huff_region_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;

  huff_region_sched_if intf ();

  huff_region_sched #(.MAX_PAIRS(288)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int out_idx_q[$];
  int out_val_q[$];
  int sel_q[$];
  int exp_v[$];
  int done_cnt = 0;
  int viol_cnt = 0;
  int ob, sb, db;
  bit timed_out;

  // Toy decoder bank: 3 code bits b0 b1 b2 then a sign bit.
  // y = b0 ? table id : 0, x = b1 & b2, sign negates both.
  logic [2:0] m_sh;
  logic [1:0] m_cnt;

  function automatic logic signed [15:0] mk_val(input logic signed [15:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt          <= '0;
      m_sh           <= '0;
      intf.dec_axiov <= 1'b0;
      intf.dec_x     <= '0;
      intf.dec_y     <= '0;
    end else begin
      intf.dec_axiov <= 1'b0;
      if (intf.dec_axiiv) begin
        if (m_cnt == 2'd3) begin
          m_cnt          <= '0;
          intf.dec_axiov <= 1'b1;
          intf.dec_x     <= mk_val((m_sh[1] & m_sh[0]) ? 16'sd1 : 16'sd0, intf.dec_axiid);
          intf.dec_y     <= mk_val(m_sh[2] ? 16'(intf.dec_sel) : 16'sd0, intf.dec_axiid);
        end else begin
          m_cnt <= m_cnt + 2'd1;
          m_sh  <= {m_sh[1:0], intf.dec_axiid};
        end
      end
    end
  end

  // Output monitor on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (intf.out_valid) begin
        out_idx_q.push_back(int'(intf.out_idx));
        out_val_q.push_back(int'(intf.out_val));
      end
      if (intf.dec_axiov) sel_q.push_back(int'(intf.dec_sel));
      if (intf.done) done_cnt <= done_cnt + 1;
      if ((intf.out_valid || intf.dec_axiov) && intf.in_ready) viol_cnt <= viol_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_vals(input string tag);
    chk({tag, "_count"}, out_idx_q.size() - ob, exp_v.size());
    for (int i = 0; i < exp_v.size() && ob + i < out_idx_q.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), out_idx_q[ob + i], i);
      chk($sformatf("%s_val%0d", tag, i), out_val_q[ob + i], exp_v[i]);
    end
  endtask

  task automatic run_granule(input logic [8:0] bv, input logic [8:0] r1, input logic [8:0] r2,
                             input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2,
                             input int nbits, input logic [63:0] bits, input bit gap,
                             input int mid_start, input int stop_outs, input int limit);
    int bi;
    int k;
    ob = out_idx_q.size();
    sb = sel_q.size();
    db = done_cnt;
    @(negedge clk); #1;
    intf.big_values = bv;
    intf.r1_start   = r1;
    intf.r2_start   = r2;
    intf.tsel0      = t0;
    intf.tsel1      = t1;
    intf.tsel2      = t2;
    intf.start      = 1'b1;
    @(negedge clk); #1;
    intf.start = 1'b0;
    bi = 0;
    k  = 0;
    while (k < limit && ((stop_outs == 0) ? (done_cnt == db)
                                          : (out_idx_q.size() - ob < stop_outs))) begin
      intf.start = (k == mid_start);
      if (k == mid_start) intf.big_values = '0;
      if (bi < nbits && (!gap || $urandom_range(0, 2) != 0)) begin
        intf.in_axiiv = 1'b1;
        intf.in_axiid = bits[bi];
      end else begin
        intf.in_axiiv = 1'b0;
        intf.in_axiid = 1'b0;
      end
      #1;
      if (intf.in_axiiv && intf.in_ready) bi++;
      @(negedge clk); #1;
      k++;
    end
    intf.start    = 1'b0;
    intf.in_axiiv = 1'b0;
    timed_out     = (k >= limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nz;
    intf.start      = 1'b0;
    intf.big_values = '0;
    intf.r1_start   = '0;
    intf.r2_start   = '0;
    intf.tsel0      = '0;
    intf.tsel1      = '0;
    intf.tsel2      = '0;
    intf.in_axiiv   = 1'b0;
    intf.in_axiid   = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  intf.in_ready, 0);
    chk("rst_dec_axiiv", intf.dec_axiiv, 0);
    chk("rst_out_valid", intf.out_valid, 0);
    chk("rst_out_idx",   intf.out_idx, 0);
    chk("rst_out_val",   intf.out_val, 0);
    chk("rst_busy",      intf.busy, 0);
    chk("rst_done",      intf.done, 0);
    chk("rst_bits_used", intf.bits_used, 0);
    rst = 1'b0;

    // One pair from table 1: bits 0,1,1 then sign 1 -> x=-1, y=0.
    run_granule(9'd1, 9'd100, 9'd100, 5'd1, 5'd2, 5'd3, 4, 64'b1110, 1'b0, -1, 0, 200);
    chk("g1_timeout", timed_out, 0);
    exp_v = {-1, 0};
    check_vals("g1");
    chk("g1_bits", intf.bits_used, 4);
    chk("g1_done", done_cnt - db, 1);
    chk("g1_sel", (sel_q.size() > sb) ? sel_q[sb] : -1, 1);

    // Regions (0,1,0) with boundaries 1 and 3: pairs 0 and 3 zero-filled.
    run_granule(9'd4, 9'd1, 9'd3, 5'd0, 5'd1, 5'd0, 8, 64'b1111_0011, 1'b0, -1, 0, 200);
    chk("g2_timeout", timed_out, 0);
    exp_v = {0, 0, 0, 1, -1, -1, 0, 0};
    check_vals("g2");
    chk("g2_bits", intf.bits_used, 8);
    chk("g2_done", done_cnt - db, 1);
    chk("g2_nsel", sel_q.size() - sb, 2);
    chk("g2_sel0", (sel_q.size() > sb) ? sel_q[sb] : -1, 1);
    chk("g2_sel1", (sel_q.size() > sb + 1) ? sel_q[sb + 1] : -1, 1);

    // Empty granule: done in the cycle after start is taken, no samples.
    db = done_cnt;
    ob = out_idx_q.size();
    @(negedge clk); #1;
    intf.big_values = '0;
    intf.start      = 1'b1;
    @(negedge clk); #1;
    intf.start = 1'b0;
    chk("z_done_high", intf.done, 1);
    chk("z_busy_high", intf.busy, 1);
    @(negedge clk); #1;
    chk("z_done_low", intf.done, 0);
    chk("z_busy_low", intf.busy, 0);
    chk("z_nout",     out_idx_q.size() - ob, 0);
    chk("z_done_cnt", done_cnt - db, 1);

    // r2_start below r1_start: region 1 empty, pair 2 falls in region 2.
    run_granule(9'd3, 9'd2, 9'd1, 5'd2, 5'd5, 5'd7, 12, 64'b1001_0110_0001, 1'b0, -1, 0, 300);
    chk("g3_timeout", timed_out, 0);
    exp_v = {0, 2, 1, 0, 0, -7};
    check_vals("g3");
    chk("g3_bits", intf.bits_used, 12);
    chk("g3_sel0", (sel_q.size() > sb) ? sel_q[sb] : -1, 2);
    chk("g3_sel1", (sel_q.size() > sb + 1) ? sel_q[sb + 1] : -1, 2);
    chk("g3_sel2", (sel_q.size() > sb + 2) ? sel_q[sb + 2] : -1, 7);

    // Same as g2 with a gapped bitstream and a stray start while decoding.
    run_granule(9'd4, 9'd1, 9'd3, 5'd0, 5'd1, 5'd0, 8, 64'b1111_0011, 1'b1, 3, 0, 400);
    chk("g4_timeout", timed_out, 0);
    exp_v = {0, 0, 0, 1, -1, -1, 0, 0};
    check_vals("g4");
    chk("g4_bits", intf.bits_used, 8);
    chk("g4_done", done_cnt - db, 1);

    // Oversized big_values is clamped to 288 pairs, all zero-filled.
    run_granule(9'd300, 9'd0, 9'd0, 5'd0, 5'd0, 5'd0, 0, 64'd0, 1'b0, -1, 0, 2000);
    chk("clamp_timeout", timed_out, 0);
    chk("clamp_count", out_idx_q.size() - ob, 576);
    chk("clamp_last_idx", (out_idx_q.size() > ob) ? out_idx_q[out_idx_q.size() - 1] : -1, 575);
    nz = 0;
    for (int i = ob; i < out_val_q.size(); i++) if (out_val_q[i] != 0) nz++;
    chk("clamp_nonzero", nz, 0);
    chk("clamp_bits", intf.bits_used, 0);
    chk("clamp_done", done_cnt - db, 1);

    // Reset after three of five pairs: immediate abort, no done pulse.
    run_granule(9'd5, 9'd100, 9'd100, 5'd1, 5'd1, 5'd1, 20, 64'hF_FFFF, 1'b0, -1, 6, 300);
    chk("abort_reached", timed_out, 0);
    db = done_cnt;
    intf.in_axiiv = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_busy",      intf.busy, 0);
    chk("abort_in_ready",  intf.in_ready, 0);
    chk("abort_dec_axiiv", intf.dec_axiiv, 0);
    chk("abort_out_valid", intf.out_valid, 0);
    chk("abort_out_idx",   intf.out_idx, 0);
    chk("abort_out_val",   intf.out_val, 0);
    chk("abort_done",      intf.done, 0);
    chk("abort_bits_used", intf.bits_used, 0);
    intf.in_axiiv = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_no_done", done_cnt - db, 0);

    // Fresh granule after the abort, gapped input, restarts from index 0.
    run_granule(9'd1, 9'd100, 9'd100, 5'd1, 5'd2, 5'd3, 4, 64'b1110, 1'b1, -1, 0, 200);
    chk("g5_timeout", timed_out, 0);
    exp_v = {-1, 0};
    check_vals("g5");
    chk("g5_bits", intf.bits_used, 4);
    chk("g5_done", done_cnt - db, 1);

    chk("ready_low_on_output", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
